// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 membrane keypad scanner for the 5 kHz calculator front end.
// Drives one column low at a time, reads the active-low rows through a
// two-flop synchroniser, debounces press and release, and emits a hex key
// code with a one-cycle key_valid strobe.
// Optional build macro: KEYPAD_REPEAT_EN adds auto-repeat of key_valid
// while a key stays held (first after REPEAT_DELAY, then every REPEAT_PERIOD).
module keypad_scanner #(
    parameter int SETTLE_CYCLES   = 2,
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int REPEAT_DELAY    = 2500,
    parameter int REPEAT_PERIOD   = 500
) (
    input  logic       clk5KHz,
    input  logic       rst,
    input  logic [3:0] ROW,
    output logic [3:0] COL,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;

    // A newly driven column needs two extra cycles to reach rs through the
    // synchroniser, so the settle window is counted on top of that delay;
    // otherwise rows would be credited to the previously driven column.
    localparam int         SYNC_DEPTH = 2;
    localparam logic [4:0] HOLD_LAST  = 5'(SETTLE_CYCLES + SYNC_DEPTH - 1);
    localparam logic [7:0] DB_TARGET  = 8'(DEBOUNCE_CYCLES);
    localparam logic [7:0] REL_LAST   = 8'(DEBOUNCE_CYCLES - 1);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15 || DEBOUNCE_CYCLES < 1 ||
        DEBOUNCE_CYCLES > 255 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("keypad_scanner: parameter out of range");
    end

    // Key code for (row, col) of the keypad legend; * maps to E and # to F.
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            4'b11_11: code = 4'hD;
            default:  code = 4'h0;
        endcase
        return code;
    endfunction

    // Lowest-index row that reads low; caller guarantees at least one is low.
    function automatic logic [1:0] lowest_low(input logic [3:0] rows);
        logic [1:0] idx;
        if (!rows[0]) begin
            idx = 2'd0;
        end else if (!rows[1]) begin
            idx = 2'd1;
        end else if (!rows[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

    // One-low column drive pattern for a column index.
    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        logic [3:0] pat;
        case (idx)
            2'd0:    pat = 4'b1110;
            2'd1:    pat = 4'b1101;
            2'd2:    pat = 4'b1011;
            2'd3:    pat = 4'b0111;
            default: pat = 4'b1110;
        endcase
        return pat;
    endfunction

    logic [3:0] sync1_q, sync2_q;
    logic [1:0] state_q, state_d;
    logic [1:0] col_idx_q, col_idx_d;
    logic [3:0] col_q;
    logic [4:0] settle_q, settle_d;
    logic [1:0] cand_row_q, cand_row_d;
    logic [7:0] db_cnt_q, db_cnt_d;
    logic [7:0] rel_cnt_q, rel_cnt_d;
    logic [3:0] key_code_q, key_code_d;
    logic       key_valid_q, key_valid_d;
    logic       key_held_q, key_held_d;
    logic       cand_high_s;

    assign cand_high_s = sync2_q[cand_row_q];

`ifdef KEYPAD_REPEAT_EN
    localparam int             REP_MAX    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int             REP_W      = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

    logic [REP_W-1:0] rep_q, rep_d;
    logic             rep_first_q, rep_first_d;

    // Auto-repeat counter and first/subsequent phase flag.
    always_ff @(posedge clk5KHz or negedge rst) begin
        if (!rst) begin
            rep_q       <= {REP_W{1'b0}};
            rep_first_q <= 1'b1;
        end else begin
            rep_q       <= rep_d;
            rep_first_q <= rep_first_d;
        end
    end
`endif

    // Scan / debounce / held state machine and output next-state logic.
    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        settle_d    = settle_q;
        cand_row_d  = cand_row_q;
        db_cnt_d    = db_cnt_q;
        rel_cnt_d   = rel_cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
`ifdef KEYPAD_REPEAT_EN
        rep_d       = rep_q;
        rep_first_d = rep_first_q;
`endif
        case (state_q)
            ST_SCAN: begin
                if (settle_q == HOLD_LAST) begin
                    settle_d = 5'd0;
                    if (sync2_q == 4'b1111) begin
                        col_idx_d = col_idx_q + 2'd1;
                    end else begin
                        cand_row_d = lowest_low(sync2_q);
                        db_cnt_d   = 8'd0;
                        state_d    = ST_DEBOUNCE;
                    end
                end else begin
                    settle_d = settle_q + 5'd1;
                end
            end
            ST_DEBOUNCE: begin
                if (cand_high_s) begin
                    state_d   = ST_SCAN;
                    col_idx_d = col_idx_q + 2'd1;
                    settle_d  = 5'd0;
                end else if (db_cnt_q == DB_TARGET) begin
                    key_code_d  = key_map(cand_row_q, col_idx_q);
                    key_valid_d = 1'b1;
                    key_held_d  = 1'b1;
                    rel_cnt_d   = 8'd0;
                    state_d     = ST_HELD;
`ifdef KEYPAD_REPEAT_EN
                    rep_d       = {REP_W{1'b0}};
                    rep_first_d = 1'b1;
`endif
                end else begin
                    db_cnt_d = db_cnt_q + 8'd1;
                end
            end
            ST_HELD: begin
                if (cand_high_s) begin
`ifdef KEYPAD_REPEAT_EN
                    rep_d       = {REP_W{1'b0}};
                    rep_first_d = 1'b1;
`endif
                    if (rel_cnt_q == REL_LAST) begin
                        key_held_d = 1'b0;
                        state_d    = ST_SCAN;
                        col_idx_d  = col_idx_q + 2'd1;
                        settle_d   = 5'd0;
                    end else begin
                        rel_cnt_d = rel_cnt_q + 8'd1;
                    end
                end else begin
                    rel_cnt_d = 8'd0;
`ifdef KEYPAD_REPEAT_EN
                    if (rep_q == (rep_first_q ? REP_DELAY_LAST : REP_PERIOD_LAST)) begin
                        key_valid_d = 1'b1;
                        rep_d       = {REP_W{1'b0}};
                        rep_first_d = 1'b0;
                    end else begin
                        rep_d = rep_q + REP_W'(1);
                    end
`endif
                end
            end
            default: begin
                state_d    = ST_SCAN;
                col_idx_d  = 2'd0;
                settle_d   = 5'd0;
                key_held_d = 1'b0;
            end
        endcase
    end

    // Row synchroniser, FSM state and registered outputs.
    always_ff @(posedge clk5KHz or negedge rst) begin
        if (!rst) begin
            sync1_q     <= 4'b1111;
            sync2_q     <= 4'b1111;
            state_q     <= ST_SCAN;
            col_idx_q   <= 2'd0;
            col_q       <= 4'b1110;
            settle_q    <= 5'd0;
            cand_row_q  <= 2'd0;
            db_cnt_q    <= 8'd0;
            rel_cnt_q   <= 8'd0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            sync1_q     <= ROW;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            col_q       <= col_drive(col_idx_d);
            settle_q    <= settle_d;
            cand_row_q  <= cand_row_d;
            db_cnt_q    <= db_cnt_d;
            rel_cnt_q   <= rel_cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign COL       = col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule
